// File: rtl/audio_pkg.sv
// Shared audio types and constants for the effect blocks: sample and gain
// types, full-scale sample limits and the echo controller state encoding.
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 16;
    localparam int AUDIO_GAIN_WIDTH = 8;

    typedef logic signed [AUDIO_DATA_WIDTH-1:0] sample_t;
    typedef logic        [AUDIO_GAIN_WIDTH-1:0] gain_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(AUDIO_DATA_WIDTH-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(AUDIO_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        MIX  = 2'd2,
        OUT  = 2'd3
    } echo_state_t;

endpackage

// File: rtl/echo_ctrl_if.sv
// Sample-stream and delay-line RAM bundle of echo_ctrl. The slave modport is
// the controller's view; the master modport is the source, sink and RAM side.
interface echo_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int GAIN_WIDTH = 8
);
    logic                         pi_in_valid;
    logic                         po_in_ready;
    logic signed [DATA_WIDTH-1:0] pi_in_data;
    logic        [ADDR_WIDTH-1:0] pi_delay;
    logic        [GAIN_WIDTH-1:0] pi_gain;

    logic                         po_out_valid;
    logic                         pi_out_ready;
    logic signed [DATA_WIDTH-1:0] po_out_data;

    logic                         po_ram_wr_en;
    logic        [ADDR_WIDTH-1:0] po_ram_wr_addr;
    logic signed [DATA_WIDTH-1:0] po_ram_wr_data;
    logic                         po_ram_rd_en;
    logic        [ADDR_WIDTH-1:0] po_ram_rd_addr;
    logic signed [DATA_WIDTH-1:0] pi_ram_rd_data;

    modport slave (
        input  pi_in_valid, pi_in_data, pi_delay, pi_gain, pi_out_ready, pi_ram_rd_data,
        output po_in_ready, po_out_valid, po_out_data,
               po_ram_wr_en, po_ram_wr_addr, po_ram_wr_data, po_ram_rd_en, po_ram_rd_addr
    );

    modport master (
        output pi_in_valid, pi_in_data, pi_delay, pi_gain, pi_out_ready, pi_ram_rd_data,
        input  po_in_ready, po_out_valid, po_out_data,
               po_ram_wr_en, po_ram_wr_addr, po_ram_wr_data, po_ram_rd_en, po_ram_rd_addr
    );

endinterface

// File: rtl/sat_mix.sv
// Combinational wet/dry mixer: y = sat(x + ((d * g) >>> GAIN_WIDTH)).
// d is signed, g is unsigned Q0.GAIN_WIDTH; the shift floors toward -inf.
// wet_en = 0 drops the wet term so y = x. Reused by other effect blocks.
module sat_mix
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int GAIN_WIDTH = AUDIO_GAIN_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] d,
    input  logic        [GAIN_WIDTH-1:0] g,
    input  logic                         wet_en,
    output logic signed [DATA_WIDTH-1:0] y
);
    localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0] wet;
    logic signed [DATA_WIDTH:0]   sum;

    // Scale the delayed sample, add the dry sample and clamp to full scale.
    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so no latch can be inferred.
        y    = '0;
        // Gain gets a zero sign bit so the product is signed x unsigned.
        prod = PROD_WIDTH'(d) * PROD_WIDTH'($signed({1'b0, g}));
        // |d * g| >> GAIN_WIDTH is below 2^(DATA_WIDTH-1), so truncation is exact.
        wet  = wet_en ? DATA_WIDTH'(prod >>> GAIN_WIDTH) : '0;
        sum  = (DATA_WIDTH+1)'(x) + (DATA_WIDTH+1)'(wet);
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            y = sum[DATA_WIDTH] ? S_MIN : S_MAX;
        end else begin
            y = sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/echo_ctrl.sv
// Echo delay-line controller. One sample per handshake; a circular buffer in
// an external RAM (1-cycle registered read) supplies the sample written
// pi_delay samples earlier, which sat_mix blends into the input.
// Build option: ECHO_FEEDBACK_EN stores the mixed output (recirculating echo);
// undefined stores the dry input (single feed-forward echo).
// MEM_DEPTH must be a power of two so the pointer arithmetic wraps naturally.
module echo_ctrl
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int GAIN_WIDTH = 8
) (
    input  logic        pi_clk,
    input  logic        pi_rst_n,
    echo_ctrl_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = ADDR_WIDTH'(MEM_DEPTH - 1);

    echo_state_t state;
    echo_state_t state_nxt;

    logic signed [DATA_WIDTH-1:0] x_q;
    logic        [ADDR_WIDTH-1:0] delay_q;
    logic        [GAIN_WIDTH-1:0] gain_q;
    logic        [ADDR_WIDTH-1:0] wr_ptr;
    logic        [ADDR_WIDTH-1:0] fill;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;

    logic                         in_ready;
    logic                         rd_en;
    logic                         wr_en;
    logic                         wet_en;
    logic signed [DATA_WIDTH-1:0] mix_y;

    // State register.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake and RAM enables, all from the current state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = pi_rst_n;
                if (bus.pi_in_valid && pi_rst_n) state_nxt = READ;
            end
            READ: begin
                rd_en     = 1'b1;
                state_nxt = MIX;
            end
            MIX: begin
                wr_en     = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                if (out_valid && bus.pi_out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input capture, output register, write pointer and warm-up counter.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            x_q       <= '0;
            delay_q   <= '0;
            gain_q    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && bus.pi_in_valid) begin
                x_q     <= bus.pi_in_data;
                delay_q <= bus.pi_delay;
                gain_q  <= bus.pi_gain;
            end
            if (state == MIX) begin
                out_data  <= mix_y;
                out_valid <= 1'b1;
                if (fill != FILL_MAX) fill <= fill + ADDR_WIDTH'(1);
            end
            if (state == OUT && bus.pi_out_ready) begin
                out_valid <= 1'b0;
                wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // NOTE: the sample RAM is never cleared by reset; fill tracks how much of it holds real history.
    // A zero delay, or a delay reaching past the written history, mixes in nothing.
    assign wet_en = (delay_q != '0) && (fill >= delay_q);

    sat_mix #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_sat_mix (
        .x      (x_q),
        .d      (bus.pi_ram_rd_data),
        .g      (gain_q),
        .wet_en (wet_en),
        .y      (mix_y)
    );

    assign bus.po_in_ready    = in_ready;
    assign bus.po_out_valid   = out_valid;
    assign bus.po_out_data    = out_data;
    assign bus.po_ram_rd_en   = rd_en;
    assign bus.po_ram_rd_addr = wr_ptr - delay_q;
    assign bus.po_ram_wr_en   = wr_en;
    assign bus.po_ram_wr_addr = wr_ptr;
`ifdef ECHO_FEEDBACK_EN
    assign bus.po_ram_wr_data = mix_y;
`else
    assign bus.po_ram_wr_data = x_q;
`endif

endmodule

// File: tb/tb_echo_ctrl.sv
// Directed bench for echo_ctrl with a 16-entry delay line and a behavioural
// RAM with 1-cycle registered read. Inputs change just after edges; outputs
// are sampled on falling edges.
module tb_echo_ctrl;
    import audio_pkg::*;

    logic pi_clk = 1'b0;
    logic pi_rst_n = 1'b1;

    echo_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .GAIN_WIDTH(8)) bus ();

    echo_ctrl #(
        .DATA_WIDTH (16),
        .MEM_DEPTH  (16),
        .ADDR_WIDTH (4),
        .GAIN_WIDTH (8)
    ) u_dut (
        .pi_clk   (pi_clk),
        .pi_rst_n (pi_rst_n),
        .bus      (bus.slave)
    );

    always #5 pi_clk = ~pi_clk;

    // Behavioural sample RAM, preloaded with junk so unmasked stale reads show up.
    sample_t mem [16] = '{default: 16'sh5A5A};
    int      wr_count = 0;

    always @(posedge pi_clk) begin
        if (bus.po_ram_wr_en) begin
            mem[bus.po_ram_wr_addr] <= bus.po_ram_wr_data;
            wr_count <= wr_count + 1;
        end
        if (bus.po_ram_rd_en) bus.pi_ram_rd_data <= mem[bus.po_ram_rd_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        pi_rst_n = 1'b0;
        @(negedge pi_clk);
        @(negedge pi_clk);
        pi_rst_n = 1'b1;
    endtask

    // Offer one sample, then wait for its output and compare it (pi_out_ready assumed 1).
    task automatic send(input string tag, input sample_t x, input logic [3:0] d,
                        input gain_t g, input sample_t exp);
        bit ok;
        int lat;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge pi_clk);
            ok = bus.po_in_ready;
        end
        check({tag, "_in_ready"}, ok, 1);
        bus.pi_in_valid = 1'b1;
        bus.pi_in_data  = x;
        bus.pi_delay    = d;
        bus.pi_gain     = g;
        @(posedge pi_clk);
        #1 bus.pi_in_valid = 1'b0;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge pi_clk);
            lat++;
            ok = bus.po_out_valid;
        end
        check({tag, "_out_valid"}, ok, 1);
        check({tag, "_latency"}, lat, 3);
        check({tag, "_data"}, bus.po_out_data, exp);
    endtask

    sample_t imp_exp [13];
    int      ys [41];
    sample_t d0_vec [6];
    sample_t exp_s;
    int      w0;

    initial begin
        bus.pi_in_valid  = 1'b0;
        bus.pi_in_data   = '0;
        bus.pi_delay     = '0;
        bus.pi_gain      = '0;
        bus.pi_out_ready = 1'b1;

        // Reset state.
        #1 pi_rst_n = 1'b0;
        #2;
        check("rst_in_ready", bus.po_in_ready, 0);
        check("rst_out_valid", bus.po_out_valid, 0);
        check("rst_out_data", bus.po_out_data, 0);
        check("rst_wr_en", bus.po_ram_wr_en, 0);
        check("rst_rd_en", bus.po_ram_rd_en, 0);
        @(negedge pi_clk);
        pi_rst_n = 1'b1;
        #1 check("rel_in_ready", bus.po_in_ready, 1);

        // Impulse through a 4-sample delay at half gain.
        imp_exp = '{default: 16'sd0};
        imp_exp[0] = 16'sd1000;
        imp_exp[4] = 16'sd500;
`ifdef ECHO_FEEDBACK_EN
        imp_exp[8]  = 16'sd250;
        imp_exp[12] = 16'sd125;
`endif
        for (int n = 0; n < 13; n++)
            send($sformatf("imp%0d", n), (n == 0) ? 16'sd1000 : 16'sd0, 4'd4, 8'd128, imp_exp[n]);

        // Reset in the middle of MIX: write suppressed, everything drops to 0.
        @(negedge pi_clk);
        check("mixrst_idle", bus.po_in_ready, 1);
        bus.pi_in_valid = 1'b1;
        bus.pi_in_data  = 16'sd555;
        bus.pi_delay    = 4'd1;
        bus.pi_gain     = 8'd255;
        @(posedge pi_clk);
        #1 bus.pi_in_valid = 1'b0;
        @(posedge pi_clk);
        #2 check("mixrst_in_mix", bus.po_ram_wr_en, 1);
        w0 = wr_count;
        pi_rst_n = 1'b0;
        #1;
        check("mixrst_wr_en", bus.po_ram_wr_en, 0);
        check("mixrst_rd_en", bus.po_ram_rd_en, 0);
        check("mixrst_out_valid", bus.po_out_valid, 0);
        check("mixrst_out_data", bus.po_out_data, 0);
        check("mixrst_in_ready", bus.po_in_ready, 0);
        @(posedge pi_clk);
        #1 check("mixrst_no_write", wr_count - w0, 0);
        @(negedge pi_clk);
        pi_rst_n = 1'b1;
        #1 check("mixrst_rel_ready", bus.po_in_ready, 1);
        send("mixrst_first", 16'sd1234, 4'd1, 8'd255, 16'sd1234);

        // Saturation with D=1, g=255.
        do_reset();
        send("sat_pos0", 16'sd30000, 4'd1, 8'd255, 16'sd30000);
        send("sat_pos1", 16'sd30000, 4'd1, 8'd255, SAMPLE_MAX);
        do_reset();
        send("sat_neg0", -16'sd30000, 4'd1, 8'd255, -16'sd30000);
        send("sat_neg1", -16'sd30000, 4'd1, 8'd255, SAMPLE_MIN);

        // Ramp 1..40 with D=15 across two pointer wraps.
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            if (n <= 15) begin
                ys[n] = n;
            end else begin
`ifdef ECHO_FEEDBACK_EN
                ys[n] = n + (ys[n-15] * 128) / 256;
`else
                ys[n] = n + ((n - 15) * 128) / 256;
`endif
            end
            exp_s = 16'(ys[n]);
            send($sformatf("wrap%0d", n), 16'(n), 4'd15, 8'd128, exp_s);
        end

        // Backpressure: output held for 5 cycles, exactly one RAM write.
        do_reset();
        bus.pi_out_ready = 1'b0;
        w0 = wr_count;
        bus.pi_in_valid = 1'b1;
        bus.pi_in_data  = 16'sd777;
        bus.pi_delay    = 4'd2;
        bus.pi_gain     = 8'd64;
        @(posedge pi_clk);
        #1 bus.pi_in_valid = 1'b0;
        @(negedge pi_clk);
        @(negedge pi_clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge pi_clk);
            check($sformatf("bp_valid%0d", i), bus.po_out_valid, 1);
            check($sformatf("bp_data%0d", i), bus.po_out_data, 777);
            check($sformatf("bp_in_ready%0d", i), bus.po_in_ready, 0);
            check($sformatf("bp_ram_idle%0d", i), bus.po_ram_wr_en | bus.po_ram_rd_en, 0);
        end
        check("bp_one_write", wr_count - w0, 1);
        bus.pi_out_ready = 1'b1;
        @(posedge pi_clk);
        #1;
        check("bp_release_valid", bus.po_out_valid, 0);
        check("bp_release_ready", bus.po_in_ready, 1);

        // Zero delay passes the input through bit-exactly.
        d0_vec = '{16'sd12345, -16'sd1, 16'sd32767, -16'sd32768, 16'sd0, -16'sd4321};
        for (int i = 0; i < 6; i++)
            send($sformatf("d0_%0d", i), d0_vec[i], 4'd0, 8'd255, d0_vec[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_ctrl.md
# echo_ctrl

Delay-line controller for the echo effect. Accepts one signed audio sample per handshake and drives a single-port-read/single-port-write sample RAM as a circular buffer. It reads the sample written `pi_delay` samples earlier, mixes it with the input at a programmable gain, and emits the result. It sits between the sample source and the output stage, and owns all address, enable and write-data lines of the `ram` instance (1-cycle registered read).

## Interface
- `DATA_WIDTH`, 16, signed sample width
- `MEM_DEPTH`, 4096, delay-line depth in samples; power of two required
- `ADDR_WIDTH`, `$clog2(MEM_DEPTH)`, RAM address width
- `GAIN_WIDTH`, 8, unsigned gain width, Q0.`GAIN_WIDTH`
- `pi_clk` in 1: sole clock, rising edge
- `pi_rst_n` in 1: reset, asynchronous, active-low
- `pi_in_valid` in 1: input sample valid
- `po_in_ready` out 1: input accepted when both valid and ready are high at an edge
- `pi_in_data` in `DATA_WIDTH`: signed input sample
- `pi_delay` in `ADDR_WIDTH`: echo delay in samples, sampled on accept
- `pi_gain` in `GAIN_WIDTH`: wet gain, sampled on accept
- `po_out_valid` out 1: output sample valid
- `pi_out_ready` in 1: downstream ready
- `po_out_data` out `DATA_WIDTH`: signed output sample
- `po_ram_wr_en`, `po_ram_wr_addr`, `po_ram_wr_data` out 1/`ADDR_WIDTH`/`DATA_WIDTH`: RAM write port
- `po_ram_rd_en`, `po_ram_rd_addr` out 1/`ADDR_WIDTH`: RAM read port
- `pi_ram_rd_data` in `DATA_WIDTH`: RAM read data, valid one cycle after `po_ram_rd_en`

## Operation
- FSM states and transitions:
  - IDLE → READ on input accept.
  - READ → MIX unconditionally.
  - MIX → OUT unconditionally.
  - OUT → IDLE when `po_out_valid && pi_out_ready`; otherwise hold OUT.
- `po_in_ready` = (state == IDLE) && `pi_rst_n`.
- Accept latches x, delay D and gain g into registers.
- READ: `po_ram_rd_en`=1, `po_ram_rd_addr` = (`wr_ptr` − D) mod `MEM_DEPTH`.
- MIX: d = `pi_ram_rd_data`.
  - wet = (d × g) >>> `GAIN_WIDTH`: signed × unsigned, arithmetic shift, truncation toward −∞.
  - y = sat(x + wet), saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - `po_ram_wr_en`=1, `po_ram_wr_addr`=`wr_ptr`, write data per Configuration; y registered into `po_out_data`.
- `wr_ptr` increments on the OUT→IDLE transition, wrapping `MEM_DEPTH`−1 → 0.
- Warm-up: the RAM is not cleared by reset. `fill` counts completed writes and saturates at `MEM_DEPTH`−1. wet is forced to 0 while `fill` < D.
- D = 0: wet forced to 0, so the output equals x. The RAM is still written.
- Backpressure in OUT: `po_out_data` stays stable, no RAM access, `po_in_ready`=0.

## Timing
- Accept at edge E0. `po_ram_rd_en` is high in cycle E0–E1. Write occurs at edge E2. `po_out_valid` rises after E2.
- Latency from accept to `po_out_valid` is 2 cycles. Minimum interval between accepts is 4 cycles.
- RAM enables are decoded combinationally from the state and are 0 outside READ and MIX.
- Reset (asynchronous assert, synchronous deassert is upstream's responsibility):
  - State goes to IDLE.
  - `wr_ptr`, `fill`, `po_out_data` and `po_out_valid` go to 0.
  - All RAM enables go to 0; an in-flight sample is dropped.
- Reset asserted during MIX suppresses the write.

## Configuration
- `ECHO_FEEDBACK_EN` defined: the RAM stores y, giving a recirculating, decaying echo train.
- `ECHO_FEEDBACK_EN` undefined: the RAM stores x, giving a single feed-forward echo.
- Everything else is identical in both builds.

## Structure
- `audio_pkg`:
  - `sample_t` (signed `DATA_WIDTH`)
  - `gain_t`
  - `echo_state_t` enum {IDLE, READ, MIX, OUT}
  - `SAMPLE_MAX`/`SAMPLE_MIN` constants
- Sub-module `sat_mix`: combinational multiply, shift, add and saturate. It is shared with later effect blocks.

## Test plan
All scenarios use `MEM_DEPTH`=16, `pi_out_ready`=1 unless stated.
- Reset: assert `pi_rst_n`=0 mid-MIX → all outputs 0 immediately, no write. After release, `po_in_ready`=1 and the first output equals the first input.
- Impulse, D=4, g=128, inputs 1000,0,0,…:
  - Feedback build: outputs 1000,0,0,0,500,0,0,0,250,…,125.
  - Non-feedback build: 500 once, then 0.
- Saturation, D=1, g=255: inputs 30000, 30000 → second output 32767. Inputs −30000, −30000 → −32768.
- Wrap-around, D=15, ramp inputs 1..40, g=128, non-feedback build: output n = n + ((n−15)×128>>>8) for n>15 across two pointer wraps. Outputs before warm-up completes equal n.
- Backpressure: `pi_out_ready`=0 for 5 cycles → `po_out_valid`=1 and data stable, exactly one RAM write, `po_in_ready`=0.
- D=0, g=255, random inputs → output equals input bit-exactly.
